image_frame_loader: RTL and testbench

//  Upstream stage of the face-detection top: assembles a UART byte stream into one

---
 rtl/vj_pkg.sv | 19 +
 rtl/byte_timeout_counter.sv | 28 ++
 rtl/image_frame_loader.sv | 123 ++++++++++++
 tb/tb_image_frame_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vj_pkg.sv
// Shared types for the face-detection front end.
// Loader FSM states, the default frame sync byte and the 8-bit checksum helper.
package vj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PIXELS  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running frame checksum, deliberately modulo 256.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] data);
        return 8'(acc + data);
    endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Idle-cycle watchdog between received bytes.
// Counts enabled cycles without clear; expired_c flags the LIMIT-th consecutive idle cycle.
module byte_timeout_counter #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expired_c = enable && !clear && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || clear || expired_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/image_frame_loader.sv
// Assembles a UART byte stream into a checksum-validated, double-buffered grayscale frame.
// The detector only ever sees laptop_img change on the commit edge, flagged by laptop_img_rdy.
module image_frame_loader
    import vj_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = 4,
    parameter int unsigned IMG_HEIGHT     = 3,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [7:0]                                rx_data,
    input  logic                                      rx_valid,
    input  logic                                      detect_busy,
    output logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] laptop_img,
    output logic                                      laptop_img_rdy,
    output logic                                      frame_error,
    output logic                                      overrun
);
    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    loader_state_t state, next_state;

    logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] shadow;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       sum;

    logic timeout_c;
    logic start_c, pixel_c, last_col_c, last_pixel_c, csum_c, match_c;
    logic commit_c, error_c, drop_c;

    byte_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .enable   ((state == ST_PIXELS) || (state == ST_CHECK)),
        .clear    (rx_valid),
        .expired_c(timeout_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start_c) next_state = ST_PIXELS;
            end
            ST_PIXELS: begin
                if (timeout_c)         next_state = ST_IDLE;
                else if (last_pixel_c) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (timeout_c) begin
                    next_state = ST_IDLE;
                end else if (csum_c) begin
                    next_state = (match_c && detect_busy) ? ST_PENDING : ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (!detect_busy) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Control decodes for the datapath registers below.
    always_comb begin
        start_c      = (state == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
        pixel_c      = (state == ST_PIXELS) && rx_valid;
        last_col_c   = (col == COL_W'(IMG_WIDTH - 1));
        last_pixel_c = pixel_c && last_col_c && (row == ROW_W'(IMG_HEIGHT - 1));
        csum_c       = (state == ST_CHECK) && rx_valid;
        match_c      = (rx_data == sum);
        commit_c     = (csum_c && match_c && !detect_busy) ||
                       ((state == ST_PENDING) && !detect_busy);
        error_c      = (csum_c && !match_c) || timeout_c;
        drop_c       = (state == ST_PENDING) && rx_valid;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow         <= '0;
            laptop_img     <= '0;
            row            <= '0;
            col            <= '0;
            sum            <= '0;
            laptop_img_rdy <= 1'b0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            laptop_img_rdy <= commit_c;
            frame_error    <= error_c;
            if (drop_c) overrun <= 1'b1;
            if (commit_c) laptop_img <= shadow;
            if (start_c) begin
                row <= '0;
                col <= '0;
                sum <= '0;
            end else if (pixel_c) begin
                shadow[row][col] <= rx_data;
                sum              <= sum8(sum, rx_data);
                if (last_col_c) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Scoreboard bench for image_frame_loader with a 4x3 frame and a 50-cycle byte timeout.
// Stimulus queues expected rdy/error pulses; a negedge monitor pops and checks them.
module tb_image_frame_loader;
    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
    localparam int unsigned N = W * H;

    typedef logic [H-1:0][W-1:0][7:0] img_t;
    typedef struct packed {
        logic kind;   // 0 = commit (rdy), 1 = frame_error
        img_t img;    // laptop_img required while the pulse is high
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       detect_busy;
    img_t       laptop_img;
    logic       laptop_img_rdy;
    logic       frame_error;
    logic       overrun;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    img_t committed = '0;
    img_t model     = '0;

    image_frame_loader #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .detect_busy   (detect_busy),
        .laptop_img    (laptop_img),
        .laptop_img_rdy(laptop_img_rdy),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per pulse and guards laptop_img stability.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            model = '0;
        end else begin
            if (laptop_img_rdy || frame_error) begin
                chk("pulse_exclusive", 96'(laptop_img_rdy && frame_error), 96'(0));
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 96'({laptop_img_rdy, frame_error}), 96'(0));
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", 96'(frame_error), 96'(e.kind));
                    chk("img_at_pulse", laptop_img, e.img);
                    if (laptop_img_rdy) model = e.img;
                end
            end
            chk("img_stable", laptop_img, model);
        end
    end

    // Drives one byte for exactly one cycle; entered and left at posedge+1.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] step,
                              input logic [7:0] csum, input logic good);
        img_t img;
        logic [7:0] p;
        send(8'hA5);
        for (int i = 0; i < int'(N); i++) begin
            p = 8'(base + 8'(i) * step);
            img[i / W][i % W] = p;
            send(p);
        end
        if (good) q.push_back('{kind: 1'b0, img: img});
        else      q.push_back('{kind: 1'b1, img: committed});
        send(csum);
        if (good) committed = img;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk(name, 96'(q.size()), 96'(0));
            q.delete();
        end
    endtask

    initial begin
        reset       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        detect_busy = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_img", laptop_img, 96'(0));
        chk("reset_rdy", 96'(laptop_img_rdy), 96'(0));
        chk("reset_err", 96'(frame_error), 96'(0));
        chk("reset_overrun", 96'(overrun), 96'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Noise before sync is ignored; then a good frame 1..12 with checksum 0x4E.
        send(8'h11);
        send(8'h22);
        send_frame(8'd1, 8'd1, 8'h4E, 1'b1);
        drain("good_frame_timeout", 10);
        chk("good_pix00", 96'(laptop_img[0][0]), 96'(8'd1));
        chk("good_pix23", 96'(laptop_img[2][3]), 96'(8'd12));

        // Bad checksum keeps the previous frame.
        send_frame(8'd1, 8'd1, 8'h4F, 1'b0);
        drain("bad_csum_timeout", 10);

        // Detector busy: frame 0x10 + 3*i, checksum 0x86, held until busy drops.
        chk("overrun_before", 96'(overrun), 96'(0));
        detect_busy = 1'b1;
        send_frame(8'h10, 8'd3, 8'h86, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        send(8'h77);
        chk("overrun_set", 96'(overrun), 96'(1));
        repeat (15) @(posedge clock);
        #1;
        chk("rdy_held", 96'(laptop_img_rdy), 96'(0));
        chk("queue_held", 96'(q.size()), 96'(1));
        detect_busy = 1'b0;
        @(posedge clock);
        #1;
        chk("rdy_after_busy", 96'(laptop_img_rdy), 96'(1));
        drain("busy_hold_timeout", 10);
        chk("overrun_sticky", 96'(overrun), 96'(1));

        // Timeout after sync + 5 pixels, then a normal frame commits.
        send(8'hA5);
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
        q.push_back('{kind: 1'b1, img: committed});
        drain("timeout_error_missing", 80);
        send_frame(8'd1, 8'd1, 8'h4E, 1'b1);
        drain("post_timeout_frame", 10);

        // Sync value as pixel data: 12 x 0xA5 sums to 0x7BC, checksum 0xBC.
        send_frame(8'hA5, 8'd0, 8'hBC, 1'b1);
        drain("sync_data_frame", 10);
        chk("sync_pix12", 96'(laptop_img[1][2]), 96'(8'hA5));

        // Asynchronous reset mid-PIXELS, asserted between clock edges.
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        #2;
        reset = 1'b0;
        #1;
        chk("async_img", laptop_img, 96'(0));
        chk("async_overrun", 96'(overrun), 96'(0));
        chk("async_rdy", 96'(laptop_img_rdy), 96'(0));
        committed = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (70) @(posedge clock);
        #1;
        chk("no_pulse_after_reset", 96'(q.size()), 96'(0));

        // Recovery frame F0..FB, checksum 0x82.
        send_frame(8'hF0, 8'd1, 8'h82, 1'b1);
        drain("recovery_frame", 10);
        chk("recovery_pix00", 96'(laptop_img[0][0]), 96'(8'hF0));
        repeat (3) @(posedge clock);
        chk("queue_empty_end", 96'(q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
